// File: rtl/cnn_pool_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pool_stream_pkg
//  Description : Shared constants and the signed saturation helper used by
//                the CNN pooling stage and neighbouring pipeline stages.
//                C_CNN_CH / C_CNN_IDW / C_CNN_ODW are the channel count and
//                the convolution-output / pooled-output widths of stage 1.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pool_stream_pkg;

    localparam int C_CNN_CH  = 3;
    localparam int C_CNN_IDW = 20;
    localparam int C_CNN_ODW = 8;

    // Working width for the saturation helper; callers sign-extend into it.
    localparam int C_SAT_W = 40;

    // Signed saturation test: 1 when val lies outside the range of a signed
    // integer of 'width' bits. Callers form the clamped value from the sign
    // of val, so only the decision is shared here.
    function automatic logic sat_out_of_range(
        input logic signed [C_SAT_W-1:0] val,
        input int unsigned               width
    );
        logic signed [C_SAT_W-1:0] hi;
        logic signed [C_SAT_W-1:0] lo;
        hi = (C_SAT_W'(1) <<< (width - 1)) - C_SAT_W'(1);
        lo = ~hi;                       // -(2^(width-1))
        return (val > hi) || (val < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_pool_stream_lane.sv
`default_nettype none
// ============================================================================
//  Module      : pool_max_lane
//  Description : One channel of the pooling stage. Stage 1 registers the
//                requantised (shift, saturate, optional ReLU) input value and
//                its saturation bit. Stage 2 keeps the horizontal running max
//                over a pooling window.
//  Ports       : clk, reset      - clock, async active-high reset
//                i_valid         - stage-1 load strobe
//                i_relu          - ReLU enable for this beat
//                i_data          - signed input sample (IDW bits)
//                i_s2_en         - stage 2 consumes the stage-1 value
//                i_s2_load       - first column of a window (restart max)
//                o_row_max       - row max including current stage-1 value
//                o_sat           - saturation bit of the stage-1 value
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_max_lane
    import cnn_pool_stream_pkg::*;
#(
    parameter int IDW   = C_CNN_IDW,
    parameter int ODW   = C_CNN_ODW,
    parameter int SHIFT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_valid,
    input  logic           i_relu,
    input  logic [IDW-1:0] i_data,
    input  logic           i_s2_en,
    input  logic           i_s2_load,
    output logic [ODW-1:0] o_row_max,
    output logic           o_sat
);

    logic signed [C_SAT_W-1:0] w_ext;
    logic signed [C_SAT_W-1:0] w_shift;
    logic                      w_clamped;
    logic signed [ODW-1:0]     w_sat_val;
    logic signed [ODW-1:0]     w_q;
    logic signed [ODW-1:0]     w_max;
    logic signed [ODW-1:0]     w_row;

    logic signed [ODW-1:0]     r_s1_val;
    logic                      r_s1_sat;
    logic signed [ODW-1:0]     r_hmax;

    assign w_ext     = {{(C_SAT_W-IDW){i_data[IDW-1]}}, i_data};
    assign w_shift   = w_ext >>> SHIFT;
    assign w_clamped = sat_out_of_range(w_shift, ODW);

    // Clamp to the most positive / most negative ODW value by sign.
    assign w_sat_val = w_clamped ? {w_shift[C_SAT_W-1], {(ODW-1){~w_shift[C_SAT_W-1]}}}
                                 : w_shift[ODW-1:0];
    assign w_q       = (i_relu && w_sat_val[ODW-1]) ? '0 : w_sat_val;

    assign w_max     = (r_hmax > r_s1_val) ? r_hmax : r_s1_val;
    assign w_row     = i_s2_load ? r_s1_val : w_max;
    assign o_row_max = w_row;
    assign o_sat     = r_s1_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_val <= '0;
            r_s1_sat <= 1'b0;
            r_hmax   <= '0;
        end else begin
            if (i_valid) begin
                r_s1_val <= w_q;
                r_s1_sat <= w_clamped;
            end
            if (i_s2_en) begin
                r_hmax <= w_row;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_pool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pool_stream
//  Description : Streaming requantise + ReLU + POOLxPOOL max-pool stage.
//                Raster input, one beat per i_valid, no backpressure. Two
//                register stages: requantise, then pool/output.
//  Ports       : clk, reset      - clock, async active-high reset
//                i_relu_en       - ReLU enable, latched on a frame's 1st beat
//                i_valid/i_fmap  - input beat, channel c at [c*IDW +: IDW]
//                o_valid/o_fmap  - pooled beat, channel c at [c*ODW +: ODW]
//                o_x/o_y         - output coordinate of the pooled beat
//                o_frame_done    - pulse with the last output of a frame
//                o_sat           - sticky per-frame saturation flag
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_pool_stream
    import cnn_pool_stream_pkg::*;
#(
    parameter int CH    = C_CNN_CH,
    parameter int IDW   = C_CNN_IDW,
    parameter int ODW   = C_CNN_ODW,
    parameter int SHIFT = 4,
    parameter int IN_W  = 24,
    parameter int IN_H  = 24,
    parameter int POOL  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_relu_en,
    input  logic                          i_valid,
    input  logic [CH*IDW-1:0]             i_fmap,
    output logic                          o_valid,
    output logic [CH*ODW-1:0]             o_fmap,
    output logic [$clog2(IN_W/POOL)-1:0]  o_x,
    output logic [$clog2(IN_H/POOL)-1:0]  o_y,
    output logic                          o_frame_done,
    output logic                          o_sat
);

    localparam int OUT_W = IN_W / POOL;
    localparam int OUT_H = IN_H / POOL;
    localparam int C_XW  = $clog2(IN_W);
    localparam int C_YW  = $clog2(IN_H);
    localparam int C_PW  = $clog2(POOL);
    localparam int C_OXW = $clog2(OUT_W);
    localparam int C_OYW = $clog2(OUT_H);

    // Input position: pixel coordinate plus position inside / index of window.
    logic [C_XW-1:0] r_x;
    logic [C_XW-1:0] r_ox;
    logic [C_PW-1:0] r_px;
    logic [C_YW-1:0] r_y;
    logic [C_YW-1:0] r_oy;
    logic [C_PW-1:0] r_py;
    logic            r_relu;

    // Stage-1 window metadata travelling alongside the lane registers.
    logic            r_s1_valid;
    logic            r_s1_load;
    logic            r_s1_hlast;
    logic            r_s1_vfirst;
    logic            r_s1_vlast;
    logic            r_s1_keep;
    logic            r_s1_first;
    logic [C_XW-1:0] r_s1_ox;
    logic [C_YW-1:0] r_s1_oy;

    logic [CH*ODW-1:0] r_lbuf [OUT_W];

    logic              r_o_valid;
    logic [CH*ODW-1:0] r_o_fmap;
    logic [C_OXW-1:0]  r_o_x;
    logic [C_OYW-1:0]  r_o_y;
    logic              r_o_done;
    logic              r_sat;

    logic              w_first_beat;
    logic              w_relu;
    logic [CH-1:0]     w_lane_sat;
    logic [CH*ODW-1:0] w_vmerge;
    logic [CH*ODW-1:0] w_lb_rd;
    logic [C_OXW-1:0]  w_lb_idx;
    logic              w_win_end;
    logic              w_emit;
    logic              w_lb_we;
    logic              w_last_win;

    assign w_first_beat = i_valid && (r_x == '0) && (r_y == '0);
    assign w_relu       = w_first_beat ? i_relu_en : r_relu;

    // ------------------------------------------------------------------
    // Input raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x    <= '0;
            r_ox   <= '0;
            r_px   <= '0;
            r_y    <= '0;
            r_oy   <= '0;
            r_py   <= '0;
            r_relu <= 1'b0;
        end else if (i_valid) begin
            if (w_first_beat) begin
                r_relu <= i_relu_en;
            end
            if (r_x == C_XW'(IN_W - 1)) begin
                r_x  <= '0;
                r_ox <= '0;
                r_px <= '0;
                if (r_y == C_YW'(IN_H - 1)) begin
                    r_y  <= '0;
                    r_oy <= '0;
                    r_py <= '0;
                end else begin
                    r_y <= r_y + 1'b1;
                    if (r_py == C_PW'(POOL - 1)) begin
                        r_py <= '0;
                        r_oy <= r_oy + 1'b1;
                    end else begin
                        r_py <= r_py + 1'b1;
                    end
                end
            end else begin
                r_x <= r_x + 1'b1;
                if (r_px == C_PW'(POOL - 1)) begin
                    r_px <= '0;
                    r_ox <= r_ox + 1'b1;
                end else begin
                    r_px <= r_px + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage-1 metadata
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_load   <= 1'b0;
            r_s1_hlast  <= 1'b0;
            r_s1_vfirst <= 1'b0;
            r_s1_vlast  <= 1'b0;
            r_s1_keep   <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_ox     <= '0;
            r_s1_oy     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_load   <= (r_px == '0);
                r_s1_hlast  <= (r_px == C_PW'(POOL - 1));
                r_s1_vfirst <= (r_py == '0);
                r_s1_vlast  <= (r_py == C_PW'(POOL - 1));
                // Partial windows at the right/bottom edge are dropped.
                r_s1_keep   <= (r_ox < C_XW'(OUT_W)) && (r_oy < C_YW'(OUT_H));
                r_s1_first  <= w_first_beat;
                r_s1_ox     <= r_ox;
                r_s1_oy     <= r_oy;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel lanes and vertical merge against the line buffer
    // ------------------------------------------------------------------
    assign w_lb_idx = r_s1_ox[C_OXW-1:0];
    assign w_lb_rd  = r_lbuf[w_lb_idx];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_lane
            logic signed [ODW-1:0] w_row;
            logic signed [ODW-1:0] w_lb;

            pool_max_lane #(
                .IDW   (IDW),
                .ODW   (ODW),
                .SHIFT (SHIFT)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .i_valid   (i_valid),
                .i_relu    (w_relu),
                .i_data    (i_fmap[gi*IDW +: IDW]),
                .i_s2_en   (r_s1_valid),
                .i_s2_load (r_s1_load),
                .o_row_max (w_row),
                .o_sat     (w_lane_sat[gi])
            );

            assign w_lb = w_lb_rd[gi*ODW +: ODW];
            // First window row overwrites whatever an earlier frame left.
            assign w_vmerge[gi*ODW +: ODW] = (r_s1_vfirst || (w_row > w_lb)) ? w_row : w_lb;
        end
    endgenerate

    assign w_win_end  = r_s1_valid && r_s1_keep && r_s1_hlast;
    assign w_emit     = w_win_end && r_s1_vlast;
    assign w_lb_we    = w_win_end && !r_s1_vlast;
    assign w_last_win = (r_s1_ox == C_XW'(OUT_W - 1)) && (r_s1_oy == C_YW'(OUT_H - 1));

    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_lbuf[w_lb_idx] <= w_vmerge;
        end
    end

    // ------------------------------------------------------------------
    // Output register and sticky saturation flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_o_valid <= 1'b0;
            r_o_fmap  <= '0;
            r_o_x     <= '0;
            r_o_y     <= '0;
            r_o_done  <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_o_valid <= w_emit;
            r_o_done  <= w_emit && w_last_win;
            if (w_emit) begin
                r_o_fmap <= w_vmerge;
                r_o_x    <= r_s1_ox[C_OXW-1:0];
                r_o_y    <= r_s1_oy[C_OYW-1:0];
            end
            // Pixel (0,0) restarts the flag; its own saturation still sets it.
            if (r_s1_valid) begin
                r_sat <= (r_sat & ~r_s1_first) | (|w_lane_sat);
            end
        end
    end

    assign o_valid      = r_o_valid;
    assign o_fmap       = r_o_fmap;
    assign o_x          = r_o_x;
    assign o_y          = r_o_y;
    assign o_frame_done = r_o_done;
    assign o_sat        = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_cnn_pool_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnn_pool_stream
//  Description : Self-checking bench for cnn_pool_stream. Two instances
//                (4x4 and 5x5 frames, CH=2, IDW=16, ODW=8, SHIFT=4, POOL=2)
//                are driven with directed and random frames; expected pooled
//                beats come from a frame-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cnn_pool_stream;

    localparam int CH    = 2;
    localparam int IDW   = 16;
    localparam int ODW   = 8;
    localparam int SHIFT = 4;
    localparam int POOL  = 2;

    typedef struct {
        int c0;
        int c1;
        int x;
        int y;
        int done;
        int sat;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              relu_en [2];
    logic              valid   [2];
    logic [CH*IDW-1:0] fmap    [2];
    logic              ov      [2];
    logic [CH*ODW-1:0] ofm     [2];
    logic [0:0]        ox      [2];
    logic [0:0]        oy      [2];
    logic              odone   [2];
    logic              osat    [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: requantised pixels of the frame in progress.
    int pix   [2][5][5][2];
    int mx    [2];
    int my    [2];
    int mrelu [2];
    int msat  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cnn_pool_stream #(
        .CH(CH), .IDW(IDW), .ODW(ODW), .SHIFT(SHIFT), .IN_W(4), .IN_H(4), .POOL(POOL)
    ) dut (
        .clk(clk), .reset(reset), .i_relu_en(relu_en[0]), .i_valid(valid[0]),
        .i_fmap(fmap[0]), .o_valid(ov[0]), .o_fmap(ofm[0]), .o_x(ox[0]), .o_y(oy[0]),
        .o_frame_done(odone[0]), .o_sat(osat[0])
    );

    cnn_pool_stream #(
        .CH(CH), .IDW(IDW), .ODW(ODW), .SHIFT(SHIFT), .IN_W(5), .IN_H(5), .POOL(POOL)
    ) dut_odd (
        .clk(clk), .reset(reset), .i_relu_en(relu_en[1]), .i_valid(valid[1]),
        .i_fmap(fmap[1]), .o_valid(ov[1]), .o_fmap(ofm[1]), .o_x(ox[1]), .o_y(oy[1]),
        .o_frame_done(odone[1]), .o_sat(osat[1])
    );

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_w(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int requant(input int v, input int relu, output int s);
        int t;
        t = v >>> SHIFT;
        s = 0;
        if (t > 127)  begin t = 127;  s = 1; end
        if (t < -128) begin t = -128; s = 1; end
        if (relu != 0 && t < 0) t = 0;
        return t;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) q0.delete(0);
        else        q1.delete(0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) valid[k] = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0; my[k] = 0; mrelu[k] = 0; msat[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One input beat to instance d, plus the model's view of it.
    task automatic drive_beat(input int d, input int v0, input int v1, input int relu);
        int   s0, s1, ow, bx, by;
        exp_t e;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) valid[k] = 1'b0;
        valid[d]   = 1'b1;
        relu_en[d] = relu[0];
        fmap[d]    = {v1[15:0], v0[15:0]};

        if (mx[d] == 0 && my[d] == 0) begin
            mrelu[d] = relu;
            msat[d]  = 0;
        end
        pix[d][my[d]][mx[d]][0] = requant(v0, mrelu[d], s0);
        pix[d][my[d]][mx[d]][1] = requant(v1, mrelu[d], s1);
        msat[d] = msat[d] | s0 | s1;

        ow = frame_w(d) / POOL;
        if (mx[d] % POOL == POOL - 1 && my[d] % POOL == POOL - 1 &&
            mx[d] / POOL < ow && my[d] / POOL < ow) begin
            bx = mx[d] - (POOL - 1);
            by = my[d] - (POOL - 1);
            e.c0 = -1000;
            e.c1 = -1000;
            for (int j = 0; j < POOL; j++) begin
                for (int i = 0; i < POOL; i++) begin
                    if (pix[d][by+j][bx+i][0] > e.c0) e.c0 = pix[d][by+j][bx+i][0];
                    if (pix[d][by+j][bx+i][1] > e.c1) e.c1 = pix[d][by+j][bx+i][1];
                end
            end
            e.x    = mx[d] / POOL;
            e.y    = my[d] / POOL;
            e.done = (e.x == ow - 1 && e.y == ow - 1) ? 1 : 0;
            e.sat  = msat[d];
            e.cyc  = cyc + 2;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end

        if (mx[d] == frame_w(d) - 1) begin
            mx[d] = 0;
            my[d] = (my[d] == frame_w(d) - 1) ? 0 : my[d] + 1;
        end else begin
            mx[d] = mx[d] + 1;
        end
    endtask

    function automatic int rand_sample();
        logic signed [15:0] t16;
        if ($urandom_range(0, 15) == 0) begin
            t16 = 16'($urandom);
            return int'(t16);
        end
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    // mode: 0 ramp/mirror, 1 one saturating pixel, 2 zeros, 3 all 0x8000,
    //       4 all -160, 5 random. relu is inverted from beat 'flip' onward.
    task automatic run_frame(input int d, input int mode, input int relu,
                             input int maxgap, input int flip, input int nbeats);
        int w, v0, v1, r, n;
        w = frame_w(d);
        n = 0;
        for (int y = 0; y < w; y++) begin
            for (int x = 0; x < w; x++) begin
                if (n < nbeats) begin
                    case (mode)
                        0: begin v0 = (x + w * y) * 16; v1 = -v0; end
                        1: begin v0 = (x == 1 && y == 0) ? 32'h7FF0 : 0; v1 = 0; end
                        2: begin v0 = 0; v1 = 0; end
                        3: begin v0 = -32768; v1 = -32768; end
                        4: begin v0 = -160; v1 = -160; end
                        default: begin v0 = rand_sample(); v1 = rand_sample(); end
                    endcase
                    r = (flip >= 0 && n >= flip) ? (1 - relu) : relu;
                    if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
                    drive_beat(d, v0, v1, r);
                    n++;
                end
            end
        end
    endtask

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_valid%0d", d), ov[d], 0);
            check_eq($sformatf("rst_fmap%0d", d), ofm[d], 0);
            check_eq($sformatf("rst_x%0d", d), ox[d], 0);
            check_eq($sformatf("rst_y%0d", d), oy[d], 0);
            check_eq($sformatf("rst_done%0d", d), odone[d], 0);
            check_eq($sformatf("rst_sat%0d", d), osat[d], 0);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    exp_t me;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (qsize(d) > 0) begin
                me = qfront(d);
                if (me.cyc < cyc) begin
                    check_eq($sformatf("missing_out%0d", d), ov[d], 1);
                    qpop(d);
                end
            end
            if (ov[d]) begin
                if (qsize(d) == 0) begin
                    check_eq($sformatf("spurious_valid%0d", d), ov[d], 0);
                end else begin
                    me = qfront(d);
                    qpop(d);
                    check_eq($sformatf("d%0d_ch0", d), $signed(ofm[d][7:0]), me.c0);
                    check_eq($sformatf("d%0d_ch1", d), $signed(ofm[d][15:8]), me.c1);
                    check_eq($sformatf("d%0d_x", d), ox[d], me.x);
                    check_eq($sformatf("d%0d_y", d), oy[d], me.y);
                    check_eq($sformatf("d%0d_done", d), odone[d], me.done);
                    check_eq($sformatf("d%0d_sat", d), osat[d], me.sat);
                    check_eq($sformatf("d%0d_latency", d), cyc, me.cyc);
                end
            end else if (odone[d]) begin
                check_eq($sformatf("done_no_valid%0d", d), odone[d], 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; relu_en[k] = 1'b0; fmap[k] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset();
        reset = 1'b0;

        // Ramp / mirror, then saturation, clear, negative saturation, ReLU.
        run_frame(0, 0, 0, 0, -1, 16);
        idle(4);
        run_frame(0, 1, 0, 0, -1, 16);
        run_frame(0, 2, 0, 0, -1, 16);
        run_frame(0, 3, 0, 0, -1, 16);
        idle(3);
        run_frame(0, 4, 1, 0, 5, 16);
        run_frame(0, 4, 0, 0, 5, 16);
        idle(4);

        // Odd frame size: column 4 and row 4 are discarded.
        run_frame(1, 0, 0, 0, -1, 25);
        idle(4);

        // Gapped ramp.
        run_frame(0, 0, 0, 3, -1, 16);
        idle(4);

        // Reset mid-frame, then back-to-back frames.
        run_frame(0, 0, 0, 0, -1, 6);
        idle(3);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset();
        reset = 1'b0;
        run_frame(0, 5, 0, 0, -1, 16);
        run_frame(0, 0, 0, 0, -1, 16);
        idle(4);

        // Random frames with random gaps and ReLU on both instances.
        for (int f = 0; f < 12; f++) begin
            run_frame(f % 2, 5, int'($urandom_range(0, 1)), (f % 3 == 0) ? 0 : 2,
                      (f % 4 == 1) ? 7 : -1, 25);
        end
        idle(6);

        check_eq("pending_dut0", q0.size(), 0);
        check_eq("pending_dut1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
